// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave transmit path.
package i2c_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam logic [BYTE_WIDTH-1:0] DEFAULT_IDLE_FILL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/i2c_byte_fifo.sv
// Synchronous byte FIFO with push/pop/flush and a registered fill level.
module i2c_byte_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];
    assign wr    = push && !full;
    assign rd    = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(wr) - LW'(rd);
        end
    end

endmodule

// File: rtl/i2c_slave_tx_feeder.sv
// Buffers application bytes and serves them MSB-first to the I2C write-byte stage.
module i2c_slave_tx_feeder
    import i2c_pkg::*;
#(
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [BYTE_WIDTH-1:0] IDLE_FILL  = DEFAULT_IDLE_FILL
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [BYTE_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          byte_request,
    input  logic                          abort,
    input  logic                          flush,
    output logic                          write_enable,
    output logic                          write_data,
    input  logic                          write_load,
    input  logic                          write_finish,
    output logic                          underrun,
    output logic                          byte_sent,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(BYTE_WIDTH) + 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BYTE_WIDTH);

    feeder_state_e         state;
    feeder_state_e         state_next;
    logic [BYTE_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic [BYTE_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  serve;
    logic                  shift_en;
    logic                  enable_next;
    logic                  underrun_next;
    logic                  sent_next;

    assign tx_ready   = !fifo_full;
    assign fifo_push  = tx_valid && tx_ready;
    assign write_data = shift_reg[BYTE_WIDTH-1];

    i2c_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .flush     (flush),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (byte_request) state_next = ST_START;
                ST_START: state_next = ST_SHIFT;
                ST_SHIFT: if (write_finish) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Pulse outputs are computed from the next state so they register in step with it.
    always_comb begin
        serve         = (state == ST_IDLE) && byte_request && !abort;
        fifo_pop      = serve && !fifo_empty;
        underrun_next = serve && fifo_empty;
        enable_next   = (state_next == ST_START);
        sent_next     = (state == ST_SHIFT) && write_finish && !abort;
        shift_en      = (state == ST_SHIFT) && write_load && (bit_cnt < BIT_LAST) && !abort;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg    <= IDLE_FILL;
            bit_cnt      <= '0;
            write_enable <= 1'b0;
            underrun     <= 1'b0;
            byte_sent    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            write_enable <= enable_next;
            underrun     <= underrun_next;
            byte_sent    <= sent_next;
            busy         <= (state_next != ST_IDLE);
            if (abort) begin
                shift_reg <= IDLE_FILL;
                bit_cnt   <= '0;
            end else if (serve) begin
                shift_reg <= fifo_empty ? IDLE_FILL : fifo_head;
                bit_cnt   <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[BYTE_WIDTH-2:0], IDLE_FILL[0]};
                bit_cnt   <= bit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_tx_feeder.sv
// Scoreboard bench for i2c_slave_tx_feeder: expected pulses/bits queued by stimulus, checked by a monitor.
module tb_i2c_slave_tx_feeder;

    localparam int DEPTH = 2;
    localparam byte unsigned EV_U = 8'd1;
    localparam byte unsigned EV_E = 8'd2;
    localparam byte unsigned EV_S = 8'd3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_request;
    logic       abort;
    logic       flush;
    logic       write_enable;
    logic       write_data;
    logic       write_load;
    logic       write_finish;
    logic       underrun;
    logic       byte_sent;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_events[$];
    bit           exp_bits[$];

    always #5 clock = ~clock;

    i2c_slave_tx_feeder #(
        .FIFO_DEPTH (DEPTH),
        .IDLE_FILL  (8'hFF)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .byte_request (byte_request),
        .abort        (abort),
        .flush        (flush),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_load   (write_load),
        .write_finish (write_finish),
        .underrun     (underrun),
        .byte_sent    (byte_sent),
        .busy         (busy),
        .fifo_level   (fifo_level)
    );

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_event(input string name, input byte unsigned code);
        byte unsigned got;
        checks++;
        if (exp_events.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse at %0t, no event queued", name, $time);
        end else begin
            got = exp_events.pop_front();
            if (got != code) begin
                errors++;
                $display("FAIL %s: actual event %0d required event %0d at %0t", name, code, got, $time);
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (underrun)     check_event("underrun", EV_U);
            if (write_enable) check_event("write_enable", EV_E);
            if (byte_sent)    check_event("byte_sent", EV_S);
            if (write_load) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL write_data: load at %0t with no bit queued", $time);
                end else begin
                    bit e;
                    e = exp_bits.pop_front();
                    if (write_data !== e) begin
                        errors++;
                        $display("FAIL write_data: actual %0b required %0b at %0t", write_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic request();
        byte_request = 1'b1;
        step();
        byte_request = 1'b0;
    endtask

    task automatic load(input bit e);
        exp_bits.push_back(e);
        write_load = 1'b1;
        step();
        write_load = 1'b0;
        step();
    endtask

    task automatic finish_byte();
        exp_events.push_back(EV_S);
        write_finish = 1'b1;
        step();
        write_finish = 1'b0;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, " tx_ready"}, tx_ready, 1);
        check_val({tag, " write_enable"}, write_enable, 0);
        check_val({tag, " write_data"}, write_data, 1);
        check_val({tag, " underrun"}, underrun, 0);
        check_val({tag, " byte_sent"}, byte_sent, 0);
        check_val({tag, " busy"}, busy, 0);
        check_val({tag, " fifo_level"}, fifo_level, 0);
    endtask

    initial begin
        logic [7:0] d;
        reset_n      = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        byte_request = 1'b0;
        abort        = 1'b0;
        flush        = 1'b0;
        write_load   = 1'b0;
        write_finish = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        step();

        // Normal byte: 8'h13 served, 8'h57 remains queued.
        push_byte(8'h13);
        check_val("level after first push", fifo_level, 1);
        push_byte(8'h57);
        check_val("level after second push", fifo_level, 2);
        exp_events.push_back(EV_E);
        request();
        check_val("level after pop", fifo_level, 1);
        check_val("busy in START", busy, 1);
        step();
        d = 8'h13;
        for (int i = 7; i >= 0; i--) load(d[i]);
        finish_byte();
        check_val("busy after finish", busy, 0);

        // Flush wins over a same-cycle push.
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        flush    = 1'b1;
        step();
        tx_valid = 1'b0;
        flush    = 1'b0;
        check_val("level after flush", fifo_level, 0);

        // Underrun, with a byte pushed in the same cycle staying queued.
        exp_events.push_back(EV_U);
        exp_events.push_back(EV_E);
        tx_data      = 8'h5A;
        tx_valid     = 1'b1;
        byte_request = 1'b1;
        step();
        tx_valid     = 1'b0;
        byte_request = 1'b0;
        check_val("level after underrun push", fifo_level, 1);
        step();
        for (int i = 0; i < 8; i++) load(1'b1);
        finish_byte();
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Full FIFO back-pressure.
        push_byte(8'h9B);
        check_val("tx_ready at level 1", tx_ready, 1);
        push_byte(8'hDF);
        check_val("level full", fifo_level, 2);
        check_val("tx_ready full", tx_ready, 0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        step();
        check_val("level held while full", fifo_level, 2);
        exp_events.push_back(EV_E);
        request();
        check_val("tx_ready after pop", tx_ready, 1);
        check_val("level after pop of 9B", fifo_level, 1);
        step();
        tx_valid = 1'b0;
        check_val("level after AA accepted", fifo_level, 2);

        // Abort after three bits of 8'h9B.
        load(1'b1);
        load(1'b0);
        load(1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("busy after abort", busy, 0);
        check_val("write_data after abort", write_data, 1);
        check_val("level after abort", fifo_level, 2);
        step();

        // Next byte is 8'hDF; ten loads, the last two ignored.
        exp_events.push_back(EV_E);
        request();
        check_val("level after DF pop", fifo_level, 1);
        step();
        d = 8'hDF;
        for (int i = 7; i >= 0; i--) load(d[i]);
        load(1'b1);
        load(1'b1);
        finish_byte();
        check_val("busy after ten loads", busy, 0);

        // Asynchronous reset mid-SHIFT with a byte still queued.
        exp_events.push_back(EV_E);
        request();
        push_byte(8'h3C);
        check_val("level before reset", fifo_level, 1);
        load(1'b1);
        load(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();

        // FIFO contents were discarded: a request now underruns.
        exp_events.push_back(EV_U);
        exp_events.push_back(EV_E);
        request();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("busy after post-reset abort", busy, 0);
        repeat (3) step();

        check_val("pending events", exp_events.size(), 0);
        check_val("pending bits", exp_bits.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
